freq_window_counter: RTL
========================

Name: freq_window_counter

Overview:
- Downstream consumer of the 1 s gate generator in the frequency-meter datapath.
- Counts rising edges of an external, asynchronous test signal while Gate_Signal is high.
- On Gate_Signal fall, latches the count as the frequency result (Hz for a 1 s window) and pulses a valid strobe for the display/BCD stage.

Parameters:
- CNT_WIDTH, 28, width of the edge counter and result; count saturates at 2^CNT_WIDTH-1.
- SYNC_STAGES, 2, flip-flop stages in the Sig_In synchronizer; legal range 2..4.

Ports:
- Clk  input  1  system clock; the same clock that drives the gate generator.
- Rst_n  input  1  asynchronous active-low reset.
- Gate_Signal  input  1  measurement window from the gate generator; synchronous to Clk, high = counting window.
- Sig_In  input  1  external signal under measurement; asynchronous to Clk.
- Freq_Value  output  CNT_WIDTH  last latched edge count; holds until the next latch.
- Freq_Valid  output  1  one-cycle strobe in the cycle Freq_Value updates.
- Overflow  output  1  sticky per measurement: the latched count saturated.
- Measuring  output  1  high while in COUNT.

Behaviour:
Clock and reset:
- One clock: Clk.
- Reset is asynchronous, active-low (Rst_n).
- All state clears immediately on Rst_n low: synchronizer flops 0, gate_d 0, counter 0, state IDLE, Freq_Value 0, Freq_Valid 0, Overflow 0, Measuring 0.

Sig_In synchronizer and edge detect:
- Sig_In passes through a SYNC_STAGES-deep synchronizer plus one history flop.
- sig_rise = synchronized value & ~history.
- Latency from a Sig_In rising edge to counter increment: SYNC_STAGES+1 Clk cycles.
- Sig_In pulses shorter than 2 Clk periods are not guaranteed to count.

Gate edge detect:
- Gate_Signal is registered once into gate_d.
- gate_rise = Gate_Signal & ~gate_d.
- gate_fall = ~Gate_Signal & gate_d.

FSM (3 states):
- IDLE: entered after reset. Waits for Gate_Signal low (gate_d == 0), then moves to ARM. A window already open at reset release is discarded, never measured partially.
- ARM: on gate_rise, clears the counter to 0 (or to 1 if sig_rise is in the same cycle) and moves to COUNT.
- COUNT:
  - Measuring = 1.
  - On each sig_rise, counter += 1.
  - At 2^CNT_WIDTH-1 the counter holds and an internal ovf flag sets.
  - On gate_fall:
    - Freq_Value <= counter (+1 if sig_rise in the same cycle, subject to saturation).
    - Overflow <= ovf.
    - Freq_Valid = 1 for exactly that cycle.
    - ovf clears.
    - Return to ARM.

Timing and boundary cases:
- Latch latency: Freq_Valid asserts 1 cycle after the Clk edge where Gate_Signal is first sampled low.
- Freq_Valid is never high two cycles in a row.
- Freq_Value and Overflow change only on a Freq_Valid cycle or on reset.
- Window of zero edges: Freq_Value = 0, Freq_Valid still pulses.
- Gate_Signal glitch (high for exactly 1 cycle): treated as a valid window, latched normally.
- Reset mid-COUNT: abort with no Freq_Valid; return to IDLE and wait for the next full window.
- Counter arithmetic is unsigned CNT_WIDTH bits; no wrap-around, saturation only.

Test Plan:
- Reset release with Gate_Signal already high for 100 cycles, then low 20, then a window of 200 cycles with Sig_In period 10 cycles -> no Freq_Valid for the first partial window; after the full window, Freq_Valid one pulse, Freq_Value = 20, Overflow = 0.
- Gate high 1000 cycles, Sig_In held low -> Freq_Valid pulses, Freq_Value = 0.
- CNT_WIDTH=4, Sig_In period 4 cycles, gate high 200 cycles -> Freq_Value = 15, Overflow = 1. Next window with 3 edges -> Freq_Value = 3, Overflow = 0.
- Sig_In rising edge timed so sig_rise coincides with gate_fall, window containing 5 other edges -> Freq_Value = 6. Repeat with sig_rise coinciding with gate_rise -> counted, Freq_Value = 6.
- Rst_n pulsed low mid-COUNT after 7 edges -> outputs immediately 0, no Freq_Valid for that window. The following full window with 9 edges -> Freq_Value = 9.
- Sig_In asynchronous, period 7.3 Clk periods, gate 7300 cycles, SYNC_STAGES=3 -> Freq_Value = 1000 ±1, with Freq_Valid exactly one cycle.

Source files
------------

// File: rtl/freq_window_counter.sv
`timescale 1ns/100ps
// freq_window_counter
//   Counts rising edges of an asynchronous test signal while the 1 s gate is
//   high, and on the gate's falling edge publishes the count as the frequency
//   result together with a one-cycle valid strobe.
//
// Ports
//   Clk          system clock, shared with the gate generator
//   Rst_n        asynchronous active-low reset
//   Gate_Signal  measurement window (Clk-synchronous), high = counting
//   Sig_In       signal under measurement, asynchronous to Clk
//   Freq_Value   last latched edge count, held until the next latch
//   Freq_Valid   one-cycle strobe in the cycle Freq_Value updates
//   Overflow     latched count of the last measurement saturated
//   Measuring    high while a window is being counted
module freq_window_counter #(
   parameter int CNT_WIDTH   = 28,
   parameter int SYNC_STAGES = 2   // 2..4
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Gate_Signal,
   input  logic                 Sig_In,
   output logic [CNT_WIDTH-1:0] Freq_Value,
   output logic                 Freq_Valid,
   output logic                 Overflow,
   output logic                 Measuring
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sig_hist;
   logic                   gate_d;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   ovf;

   logic                   sig_rise, gate_rise, gate_fall;
   logic                   cnt_sat;
   logic [CNT_WIDTH-1:0]   cnt_nx;
   logic                   start, latch;

   // Synchronizer chain, edge history and registered gate.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_q   <= '0;
         sig_hist <= 1'b0;
         gate_d   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], Sig_In};
         sig_hist <= sync_q[SYNC_STAGES-1];
         gate_d   <= Gate_Signal;
      end
   end

   assign sig_rise  = sync_q[SYNC_STAGES-1] & ~sig_hist;
   assign gate_rise = Gate_Signal & ~gate_d;
   assign gate_fall = ~Gate_Signal & gate_d;

   // Saturating increment; cnt_sat marks an edge that arrived with the
   // counter already pinned at its maximum.
   assign cnt_sat = sig_rise && (cnt == CNT_MAX);
   assign cnt_nx  = (sig_rise && !cnt_sat) ? cnt + CNT_ONE : cnt;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      latch    = 1'b0;
      case (state)
         // Only leave IDLE once the gate is seen low, so a window that was
         // already open at reset release is never measured partially.
         IDLE:  if (!gate_d) state_nx = ARM;
         ARM:   if (gate_rise) begin
                   start    = 1'b1;
                   state_nx = COUNT;
                end
         COUNT: if (gate_fall) begin
                   latch    = 1'b1;
                   state_nx = ARM;
                end
         default: state_nx = IDLE;
      endcase
   end

   assign Measuring = (state == COUNT);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt        <= '0;
         ovf        <= 1'b0;
         Freq_Value <= '0;
         Freq_Valid <= 1'b0;
         Overflow   <= 1'b0;
      end else begin
         Freq_Valid <= latch;
         if (start) begin
            // An edge landing in the gate-rise cycle belongs to the window.
            cnt <= sig_rise ? CNT_ONE : '0;
            ovf <= 1'b0;
         end else if (latch) begin
            // Edge coinciding with gate fall is still counted.
            Freq_Value <= cnt_nx;
            Overflow   <= ovf | cnt_sat;
            ovf        <= 1'b0;
         end else if (state == COUNT) begin
            cnt <= cnt_nx;
            if (cnt_sat) ovf <= 1'b1;
         end
      end
   end

endmodule
